// File: rtl/pci_arbiter_pkg.sv
// rtl/pci_arbiter_pkg.sv - shared state encoding, defaults and index helper for the PCI arbiter
package pci_arbiter_pkg;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_TIMEOUT     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_BUSY  = 2'b10
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// rtl/pci_arbiter_if.sv - request/grant bus between PCI masters and the arbiter
interface pci_arbiter_if
    import pci_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IW          = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] req;
    logic                   frame;
    logic                   IRDY;
    logic [NUM_MASTERS-1:0] gnt;
    logic [IW-1:0]          bus_owner;
    logic                   owner_valid;
    logic                   timeout_evt;

    modport master (
        output req, frame, IRDY,
        input  gnt, bus_owner, owner_valid, timeout_evt
    );

    modport slave (
        input  req, frame, IRDY,
        output gnt, bus_owner, owner_valid, timeout_evt
    );
endinterface

// File: rtl/pci_arbiter_rr_select.sv
// rtl/pci_arbiter_rr_select.sv - combinational round-robin picker over active-low requests
module rr_select
    import pci_arbiter_pkg::*;
#(
    parameter int N  = DEF_NUM_MASTERS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        // Scan N positions starting at ptr; first low request wins.
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            sel = IW'(idx);
            if (!found && !req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - round-robin PCI bus arbiter with grant timeout; PCI_ARB_PARK_EN enables bus parking
module pci_arbiter
    import pci_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          rst,
    pci_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [NUM_MASTERS-1:0] ALL_HIGH = '1;
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [TW-1:0]          TMAX     = TW'(TIMEOUT - 1);

    arb_state_e             state, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic [IW-1:0]          winner;
    logic                   found;
    logic                   bus_idle;
    logic                   granted;
    logic                   own_req;
    logic                   other_req;
    logic                   park_switch;
    logic [IW-1:0]          ptr_after_owner;
    logic [NUM_MASTERS-1:0] owner_mask;

    rr_select #(.N(NUM_MASTERS), .IW(IW)) u_rr_select (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    assign bus_idle        = bus.frame & bus.IRDY;
    assign granted         = ~&gnt_q;
    assign own_req         = ~bus.req[owner_q];
    assign owner_mask      = ONE << owner_q;
    assign other_req       = |(~bus.req & ~owner_mask);
    assign ptr_after_owner = IW'(next_idx(int'(owner_q), NUM_MASTERS));

`ifdef PCI_ARB_PARK_EN
    // A parked grant to a different master must be dropped for a cycle first.
    assign park_switch = granted && (winner != owner_q);
`else
    assign park_switch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt_q     <= ALL_HIGH;
            owner_q   <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (found && !park_switch) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (!bus.frame)                    state_d = ST_BUSY;
                else if (!own_req)                 state_d = ST_IDLE;
                else if (timer_q == TMAX)          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (bus_idle) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    if (park_switch) begin
                        gnt_d = ALL_HIGH;
                    end else begin
                        gnt_d   = ~(ONE << winner);
                        owner_d = winner;
                        timer_d = '0;
                    end
                end else begin
`ifdef PCI_ARB_PARK_EN
                    gnt_d = ~(ONE << owner_q);
`else
                    gnt_d = ALL_HIGH;
`endif
                end
            end
            ST_GRANT: begin
                if (bus.frame) begin
                    if (!own_req || timer_q == TMAX) begin
                        gnt_d     = ALL_HIGH;
                        ptr_d     = ptr_after_owner;
                        timeout_d = own_req;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_BUSY: begin
                // Preemption and end-of-transaction both just release; the owner finishes its cycle.
                if (granted && (bus_idle || other_req)) begin
                    gnt_d = ALL_HIGH;
                    ptr_d = ptr_after_owner;
                end
            end
            default: begin
                gnt_d = ALL_HIGH;
            end
        endcase
        valid_d = ~&gnt_d;
    end

    assign bus.gnt         = gnt_q;
    assign bus.bus_owner   = owner_q;
    assign bus.owner_valid = valid_q;
    assign bus.timeout_evt = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb/tb_pci_arbiter.sv - directed scoreboard bench for pci_arbiter (4 masters, timeout 16)
module tb_pci_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       valid;
        logic       to;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    pci_arbiter_if #(.NUM_MASTERS(4)) bus ();

    pci_arbiter #(.NUM_MASTERS(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] r, input logic f, input logic i,
                       input logic [3:0] eg, input logic [1:0] eo,
                       input logic ev, input logic et, input string tag);
        exp_t e;
        exp_t got;
        bus.req   = r;
        bus.frame = f;
        bus.IRDY  = i;
        e.gnt = eg; e.owner = eo; e.valid = ev; e.to = et; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (bus.gnt === got.gnt) else begin
            failures++;
            $error("FAIL %s gnt observed=%b expected=%b", got.tag, bus.gnt, got.gnt);
        end
        checks++;
        assert (bus.bus_owner === got.owner) else begin
            failures++;
            $error("FAIL %s bus_owner observed=%0d expected=%0d", got.tag, bus.bus_owner, got.owner);
        end
        checks++;
        assert (bus.owner_valid === got.valid) else begin
            failures++;
            $error("FAIL %s owner_valid observed=%b expected=%b", got.tag, bus.owner_valid, got.valid);
        end
        checks++;
        assert (bus.timeout_evt === got.to) else begin
            failures++;
            $error("FAIL %s timeout_evt observed=%b expected=%b", got.tag, bus.timeout_evt, got.to);
        end
        checks++;
        assert ($countones(~bus.gnt) <= 1) else begin
            failures++;
            $error("FAIL %s onehot_gnt observed=%b expected=at_most_one_low", got.tag, bus.gnt);
        end
    endtask

    initial begin
        logic [1:0] o;
        logic [3:0] g;

        // Reset, single grant, transaction, release.
        rst = 1'b0;
        cyc(4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "reset");
        cyc(4'b1110, 1, 1, 4'b1111, 2'd0, 0, 0, "reset_req");
        rst = 1'b1;
        cyc(4'b1110, 1, 1, 4'b1110, 2'd0, 1, 0, "grant0");
        cyc(4'b1110, 0, 0, 4'b1110, 2'd0, 1, 0, "busy0");
        cyc(4'b1110, 0, 0, 4'b1110, 2'd0, 1, 0, "busy0_hold");
        cyc(4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "idle_release");

        // Round-robin with all masters requesting.
        rst = 1'b0;
        cyc(4'b0000, 1, 1, 4'b1111, 2'd0, 0, 0, "rr_reset");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            o = 2'(k % 4);
            g = ~(4'b0001 << o);
            cyc(4'b0000, 1, 1, g,       o, 1, 0, "rr_grant");
            cyc(4'b0000, 0, 0, g,       o, 1, 0, "rr_busy");
            cyc(4'b0000, 0, 0, 4'b1111, o, 0, 0, "rr_preempt");
            cyc(4'b0000, 1, 1, 4'b1111, o, 0, 0, "rr_gap");
        end

        // Timeout on master 2, then master 3 wins, then withdraws before frame.
        cyc(4'b1011, 1, 1, 4'b1011, 2'd2, 1, 0, "to_grant2");
        for (int t = 0; t < 15; t++)
            cyc(4'b0011, 1, 1, 4'b1011, 2'd2, 1, 0, "to_wait");
        cyc(4'b0011, 1, 1, 4'b1111, 2'd2, 0, 1, "timeout");
        cyc(4'b0011, 1, 1, 4'b0111, 2'd3, 1, 0, "after_timeout");
        cyc(4'b1111, 1, 1, 4'b1111, 2'd3, 0, 0, "withdraw");

        // Preemption of master 0 by master 1.
        cyc(4'b1110, 1, 1, 4'b1110, 2'd0, 1, 0, "pre_grant0");
        cyc(4'b1110, 0, 0, 4'b1110, 2'd0, 1, 0, "pre_busy0");
        cyc(4'b1100, 0, 0, 4'b1111, 2'd0, 0, 0, "preempt");
        cyc(4'b1100, 0, 0, 4'b1111, 2'd0, 0, 0, "pre_still_busy");
        cyc(4'b1100, 1, 1, 4'b1111, 2'd0, 0, 0, "pre_idle");
        cyc(4'b1100, 1, 1, 4'b1101, 2'd1, 1, 0, "pre_grant1");

        // Reset during BUSY drops the grant on the same edge.
        cyc(4'b1100, 0, 0, 4'b1101, 2'd1, 1, 0, "rst_busy");
        rst = 1'b0;
        cyc(4'b1100, 0, 0, 4'b1111, 2'd0, 0, 0, "rst_in_busy");
        rst = 1'b1;
`ifdef PCI_ARB_PARK_EN
        cyc(4'b1111, 1, 1, 4'b1110, 2'd0, 1, 0, "park_after_rst");
        cyc(4'b1101, 1, 1, 4'b1111, 2'd0, 0, 0, "park_switch");
        cyc(4'b1101, 1, 1, 4'b1101, 2'd1, 1, 0, "park_grant1");
        cyc(4'b1101, 0, 0, 4'b1101, 2'd1, 1, 0, "park_busy1");
        cyc(4'b1111, 1, 1, 4'b1111, 2'd1, 0, 0, "park_release");
        cyc(4'b1111, 1, 1, 4'b1101, 2'd1, 1, 0, "park_held");
        cyc(4'b1111, 1, 1, 4'b1101, 2'd1, 1, 0, "park_held2");
        cyc(4'b1101, 1, 1, 4'b1101, 2'd1, 1, 0, "park_regrant");
        cyc(4'b1101, 0, 0, 4'b1101, 2'd1, 1, 0, "park_regrant_busy");
`else
        cyc(4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "no_park_after_rst");
        cyc(4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0, "no_park_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting bus masters, range 2..8.
REQ-002 Parameter TIMEOUT, default 16: clocks a granted master has to assert frame before its grant is withdrawn.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-low reset.
REQ-005 Port req  input  NUM_MASTERS: per-master bus request, active-low.
REQ-006 Port frame  input  1: PCI FRAME#, active-low.
REQ-007 Port IRDY  input  1: PCI IRDY#, active-low.
REQ-008 Port gnt  output  NUM_MASTERS: per-master grant, active-low, at most one bit low at any time.
REQ-009 Port bus_owner  output  clog2(NUM_MASTERS): index of the currently granted or last granted master.
REQ-010 Port owner_valid  output  1: high when some gnt bit is low.
REQ-011 Port timeout_evt  output  1: one-cycle high pulse when a grant is withdrawn by timeout.

Function
REQ-012 The block SHALL be an FSM with states IDLE, GRANT and BUSY; all outputs SHALL be registered.
REQ-013 Bus idle SHALL mean frame high and IRDY high in the same cycle.
REQ-014 IDLE, no request low: gnt SHALL be all high.
REQ-015 IDLE, any request low: the winner SHALL be the first low req found round-robin starting at index (pointer), and gnt[winner] SHALL go low on the next edge with state GRANT and timer cleared.
REQ-016 The round-robin pointer SHALL wrap from NUM_MASTERS-1 to 0 and be set to owner+1 (mod NUM_MASTERS) whenever a grant ends.
REQ-017 GRANT, frame low: the FSM SHALL move to BUSY and keep gnt unchanged.
REQ-018 GRANT, owner req high before frame: gnt SHALL go all high and the FSM SHALL return to IDLE.
REQ-019 GRANT, timer reaches TIMEOUT-1 with frame high: gnt SHALL go all high, timeout_evt SHALL pulse, and the FSM SHALL return to IDLE.
REQ-020 BUSY, any other master's req low: gnt[owner] SHALL go high (preemption); the owner keeps the bus until idle.
REQ-021 BUSY, bus idle: the FSM SHALL return to IDLE.
REQ-022 Any change of grant between two different masters SHALL include at least one cycle with gnt all high.
REQ-023 A req and an idle bus in the same cycle SHALL both take effect: the grant is released, and arbitration occurs in the next IDLE cycle.
REQ-024 The timer SHALL be clog2(TIMEOUT) bits wide, count only in GRANT, and saturate; it SHALL NOT wrap.

Reset
REQ-025 With rst low at a clock edge: state IDLE, gnt all high, bus_owner 0, owner_valid 0, timeout_evt 0, pointer 0, timer 0.
REQ-026 Reset asserted during GRANT or BUSY SHALL drop the grant on that same edge.

Configuration
REQ-027 Macro PCI_ARB_PARK_EN defined: in IDLE with no requests, gnt[bus_owner] SHALL stay low (bus parking). A request from the parked master SHALL enter GRANT with no dead cycle. A request from another master SHALL first give one all-high cycle.
REQ-028 PCI_ARB_PARK_EN undefined: no parking; behaviour is exactly as in REQ-014.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, GRANT=2'b01, BUSY=2'b10) and the defaults for NUM_MASTERS and TIMEOUT.
REQ-030 The round-robin priority selector SHALL be one sub-module, rr_select (req vector and pointer in; winner index and found flag out; combinational).

Verification
REQ-031 Reset, then req=4'b1110 -> gnt=4'b1110 one edge later, state GRANT; frame low -> BUSY; bus idle -> gnt=4'b1111.
REQ-032 req=4'b0000 held, each master runs one transaction -> grant order 0,1,2,3,0, with an all-high gnt cycle between owners.
REQ-033 Grant to master 2, frame kept high for 16 clocks -> timeout_evt high for 1 cycle, gnt=4'b1111, next grant goes to master 3 if requesting.
REQ-034 Master 0 in BUSY, req[1] goes low -> gnt[0] high next edge; gnt[1] goes low only after the bus is idle and an IDLE cycle has passed.
REQ-035 rst low during BUSY -> gnt=4'b1111, bus_owner=0 on that edge.
REQ-036 With PCI_ARB_PARK_EN defined, master 1 finishes and no requests remain -> gnt=4'b1101 is held; req[1] low -> GRANT with no all-high cycle.
